// File: rtl/prefetch_ring_ctrl.sv
// Pointer and occupancy controller for a cyclic prefetch buffer.
// Allocates at the tail, completes out of order, retires in order, and drains in-flight entries on flush.
module prefetch_ring_ctrl #(
  parameter int unsigned LOG_DEPTH = 3,
  localparam int unsigned DEPTH = 1 << LOG_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_ack,
  output logic [LOG_DEPTH-1:0] alloc_idx,
  input  logic                 done_valid,
  input  logic [LOG_DEPTH-1:0] done_idx,
  output logic                 ret_valid,
  input  logic                 ret_ready,
  output logic [LOG_DEPTH-1:0] ret_idx,
  input  logic                 flush,
  output logic                 flush_busy,
  output logic [DEPTH-1:0]     valid_mask,
  output logic [DEPTH-1:0]     done_mask,
  output logic [LOG_DEPTH:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 err_done
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e               state_q, state_d;
  logic [LOG_DEPTH-1:0] head_q, head_d;
  logic [LOG_DEPTH-1:0] tail_q, tail_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic [DEPTH-1:0]     done_q, done_d;
  logic                 err_q, err_d;

  logic ret_fire;
  logic done_ok;
  logic done_bad;
  logic outstanding;

  // Bits lo .. hi-1 set, wrapping modulo DEPTH; lo == hi yields zero.
  function automatic logic [DEPTH-1:0] vector_mask(input logic [LOG_DEPTH-1:0] lo,
                                                   input logic [LOG_DEPTH-1:0] hi);
    logic [DEPTH-1:0]     m;
    logic [LOG_DEPTH-1:0] span;
    logic [LOG_DEPTH-1:0] off;
    span = hi - lo;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off  = LOG_DEPTH'(i) - lo;
      m[i] = (off < span);
    end
    return m;
  endfunction

  assign full  = (count_q == (LOG_DEPTH + 1)'(DEPTH));
  assign empty = (count_q == '0);

  // head == tail is both empty and full, so the occupancy count disambiguates.
  always_comb begin
    valid_mask = '0;
    if (full) begin
      valid_mask = '1;
    end else if (!empty) begin
      valid_mask = vector_mask(head_q, tail_q);
    end
  end

  assign done_mask   = valid_mask & done_q;
  assign outstanding = |(valid_mask & ~done_q);

  assign alloc_ack  = alloc_req & ~full & (state_q == StRun) & ~flush & ~rst;
  assign alloc_idx  = tail_q;
  assign ret_valid  = (state_q == StRun) & ~empty & done_q[head_q] & ~flush;
  assign ret_idx    = head_q;
  assign ret_fire   = ret_valid & ret_ready;
  assign flush_busy = (state_q == StFlush);
  assign count      = count_q;
  assign err_done   = err_q;

  assign done_ok  = done_valid & valid_mask[done_idx] & ~done_q[done_idx];
  assign done_bad = done_valid & ~done_ok;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q;
    err_d   = err_q | done_bad;

    if (done_ok) begin
      done_d[done_idx] = 1'b1;
    end

    unique case (state_q)
      StRun: begin
        if (flush) begin
          state_d = StFlush;
        end
        if (alloc_ack) begin
          tail_d         = tail_q + LOG_DEPTH'(1);
          done_d[tail_q] = 1'b0;
        end
        if (ret_fire) begin
          head_d = head_q + LOG_DEPTH'(1);
        end
        unique case ({alloc_ack, ret_fire})
          2'b10:   count_d = count_q + (LOG_DEPTH + 1)'(1);
          2'b01:   count_d = count_q - (LOG_DEPTH + 1)'(1);
          default: count_d = count_q;
        endcase
      end
      StFlush: begin
        if (!outstanding) begin
          state_d = StRun;
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
          done_d  = '0;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_prefetch_ring_ctrl.sv
// Directed bench for prefetch_ring_ctrl (DEPTH=8) with hand-computed expectations.
module tb_prefetch_ring_ctrl;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       alloc_ack;
  logic [2:0] alloc_idx;
  logic       done_valid;
  logic [2:0] done_idx;
  logic       ret_valid;
  logic       ret_ready;
  logic [2:0] ret_idx;
  logic       flush;
  logic       flush_busy;
  logic [7:0] valid_mask;
  logic [7:0] done_mask;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       err_done;

  int vectors = 0;
  int miscompares = 0;

  prefetch_ring_ctrl #(.LOG_DEPTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_req  (alloc_req),
    .alloc_ack  (alloc_ack),
    .alloc_idx  (alloc_idx),
    .done_valid (done_valid),
    .done_idx   (done_idx),
    .ret_valid  (ret_valid),
    .ret_ready  (ret_ready),
    .ret_idx    (ret_idx),
    .flush      (flush),
    .flush_busy (flush_busy),
    .valid_mask (valid_mask),
    .done_mask  (done_mask),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .err_done   (err_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    alloc_req  = 1'b1;
    done_valid = 1'b0;
    done_idx   = '0;
    ret_ready  = 1'b0;
    flush      = 1'b0;
    step();
    step();
    #1;
    chk("ack_in_rst", alloc_ack, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_vmask", valid_mask, 0);
    chk("rst_dmask", done_mask, 0);
    chk("rst_retv", ret_valid, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err_done, 0);

    // 1) fill all eight entries, ninth request refused
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fill_ack", alloc_ack, 1);
      chk("fill_idx", alloc_idx, i);
      step();
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_vmask", valid_mask, 8'hFF);
    chk("ninth_ack", alloc_ack, 0);
    step();
    chk("ninth_count", count, 8);
    alloc_req = 1'b0;

    // 2) out-of-order completion, in-order retire
    do_reset();
    alloc_req = 1'b1;
    repeat (4) step();
    alloc_req  = 1'b0;
    done_valid = 1'b1;
    done_idx   = 3'd2;
    step();
    done_idx = 3'd0;
    step();
    done_valid = 1'b0;
    ret_ready  = 1'b1;
    #1;
    chk("ooo_dmask", done_mask, 8'h05);
    chk("ooo_retv0", ret_valid, 1);
    chk("ooo_reti0", ret_idx, 0);
    step();
    chk("ooo_retv_h1", ret_valid, 0);
    chk("ooo_reti_h1", ret_idx, 1);
    chk("ooo_count3", count, 3);
    chk("ooo_vmask", valid_mask, 8'h0E);
    step();
    chk("ooo_retv_wait", ret_valid, 0);
    done_valid = 1'b1;
    done_idx   = 3'd1;
    #1;
    chk("ooo_retv_samecyc", ret_valid, 0);
    step();
    done_valid = 1'b0;
    #1;
    chk("ooo_retv1", ret_valid, 1);
    chk("ooo_reti1", ret_idx, 1);
    step();
    chk("ooo_retv2", ret_valid, 1);
    chk("ooo_reti2", ret_idx, 2);
    step();
    chk("ooo_retv_h3", ret_valid, 0);
    chk("ooo_reti_h3", ret_idx, 3);
    chk("ooo_count1", count, 1);
    chk("ooo_vmask3", valid_mask, 8'h08);
    ret_ready = 1'b0;

    // 3) wrap-around mask, simultaneous alloc and retire
    do_reset();
    alloc_req = 1'b1;
    repeat (6) step();
    alloc_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      done_valid = 1'b1;
      done_idx   = 3'(i);
      step();
    end
    done_valid = 1'b0;
    ret_ready  = 1'b1;
    repeat (6) step();
    ret_ready = 1'b0;
    #1;
    chk("wrap_empty", empty, 1);
    chk("wrap_head6", ret_idx, 6);
    alloc_req = 1'b1;
    repeat (4) step();
    alloc_req = 1'b0;
    #1;
    chk("wrap_vmask", valid_mask, 8'hC3);
    chk("wrap_count", count, 4);
    done_valid = 1'b1;
    done_idx   = 3'd6;
    step();
    done_valid = 1'b0;
    alloc_req  = 1'b1;
    ret_ready  = 1'b1;
    #1;
    chk("both_ack", alloc_ack, 1);
    chk("both_aidx", alloc_idx, 2);
    chk("both_retv", ret_valid, 1);
    chk("both_ridx", ret_idx, 6);
    step();
    alloc_req = 1'b0;
    ret_ready = 1'b0;
    #1;
    chk("both_count", count, 4);
    chk("both_vmask", valid_mask, 8'h87);

    // 5) illegal done: unallocated, duplicate, and entry being allocated
    done_valid = 1'b1;
    done_idx   = 3'd5;
    step();
    done_valid = 1'b0;
    #1;
    chk("ill_err", err_done, 1);
    chk("ill_dmask", done_mask, 0);
    done_valid = 1'b1;
    done_idx   = 3'd7;
    step();
    chk("legal7_dmask", done_mask, 8'h80);
    step();
    chk("dup_err", err_done, 1);
    chk("dup_dmask", done_mask, 8'h80);
    alloc_req = 1'b1;
    done_idx  = 3'd3;
    step();
    alloc_req  = 1'b0;
    done_valid = 1'b0;
    #1;
    chk("alloc_done_vmask", valid_mask, 8'h8F);
    chk("alloc_done_dmask", done_mask, 8'h80);
    chk("alloc_done_err", err_done, 1);

    // 4) flush drains outstanding entries 3 and 4
    do_reset();
    #1;
    chk("err_cleared", err_done, 0);
    alloc_req = 1'b1;
    repeat (5) step();
    alloc_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      done_valid = 1'b1;
      done_idx   = 3'(i);
      step();
    end
    done_valid = 1'b0;
    flush      = 1'b1;
    alloc_req  = 1'b1;
    ret_ready  = 1'b1;
    #1;
    chk("fl_cyc_ack", alloc_ack, 0);
    chk("fl_cyc_retv", ret_valid, 0);
    chk("fl_cyc_busy", flush_busy, 0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_busy", flush_busy, 1);
    chk("fl_ack", alloc_ack, 0);
    chk("fl_retv", ret_valid, 0);
    done_valid = 1'b1;
    done_idx   = 3'd3;
    step();
    chk("fl_busy_d3", flush_busy, 1);
    done_idx = 3'd4;
    step();
    done_valid = 1'b0;
    #1;
    chk("fl_busy_d4", flush_busy, 1);
    chk("fl_ack_d4", alloc_ack, 0);
    chk("fl_count_hold", count, 5);
    chk("fl_dmask", done_mask, 8'h1F);
    step();
    chk("fl_exit_busy", flush_busy, 0);
    chk("fl_exit_empty", empty, 1);
    chk("fl_exit_count", count, 0);
    chk("fl_exit_vmask", valid_mask, 0);
    chk("fl_exit_ack", alloc_ack, 1);
    chk("fl_exit_aidx", alloc_idx, 0);
    alloc_req = 1'b0;
    ret_ready = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("fl1_busy", flush_busy, 1);
    step();
    chk("fl1_done", flush_busy, 0);

    // 6) reset mid-flush
    alloc_req = 1'b1;
    repeat (2) step();
    alloc_req  = 1'b0;
    done_valid = 1'b1;
    done_idx   = 3'd5;
    step();
    done_valid = 1'b0;
    flush      = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("mid_busy", flush_busy, 1);
    chk("mid_err", err_done, 1);
    rst       = 1'b1;
    alloc_req = 1'b1;
    #1;
    chk("mid_rst_ack", alloc_ack, 0);
    step();
    rst       = 1'b0;
    alloc_req = 1'b0;
    #1;
    chk("mid_rst_busy", flush_busy, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_vmask", valid_mask, 0);
    chk("mid_rst_dmask", done_mask, 0);
    chk("mid_rst_err", err_done, 0);
    chk("mid_rst_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
